// File: rtl/phase_seq_monitor.sv
// Checks the FT->DC->EX->WB rotation of the four-phase clock-enable bus from clk_gen,
// locks after LOCK_COUNT clean rotations, and counts instruction cycles and sequencing errors.
module phase_seq_monitor #(
  parameter int LOCK_COUNT = 2,
  parameter int MAX_HOLD   = 4,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLK_FT,
  input  logic             CLK_DC,
  input  logic             CLK_EX,
  input  logic             CLK_WB,
  input  logic             CLEAR,
  output logic             LOCKED,
  output logic             PHASE_ERR,
  output logic [1:0]       CUR_PHASE,
  output logic [CNT_W-1:0] INST_CNT,
  output logic [7:0]       ERR_CNT
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t             r_state;
  logic [3:0]         r_prev_vec;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [GOOD_W-1:0]  r_good_cnt;
  logic               r_locked;
  logic               r_phase_err;
  logic [1:0]         r_cur_phase;
  logic [CNT_W-1:0]   r_inst_cnt;
  logic [7:0]         r_err_cnt;

  logic [3:0] w_vec;
  logic [3:0] w_rotl;
  logic       w_onehot;
  logic       w_hold;
  logic       w_adv;
  logic       w_skip;
  logic       w_overhold;
  logic       w_err;
  logic       w_wrap;
  logic [1:0] w_enc;

  assign w_vec    = {CLK_WB, CLK_EX, CLK_DC, CLK_FT};
  assign w_rotl   = {r_prev_vec[2:0], r_prev_vec[3]};
  assign w_onehot = (w_vec != 4'd0) && ((w_vec & (w_vec - 4'd1)) == 4'd0);
  assign w_hold   = w_onehot && (w_vec == r_prev_vec);
  assign w_adv    = w_onehot && (w_vec == w_rotl);
  assign w_skip   = w_onehot && !w_hold && !w_adv;
  // hold_cnt counts repeats after the first sample, so MAX_HOLD-1 repeats already seen
  // means this sample is the (MAX_HOLD+1)th identical one.
  assign w_overhold = w_hold && (r_hold_cnt >= HOLD_W'(MAX_HOLD - 1));
  assign w_err    = !w_onehot || w_overhold || w_skip;
  assign w_wrap   = w_adv && (w_vec == 4'b0001);

  always_comb begin
    w_enc = 2'd0;
    case (w_vec)
      4'b0010: w_enc = 2'd1;
      4'b0100: w_enc = 2'd2;
      4'b1000: w_enc = 2'd3;
      default: w_enc = 2'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_HUNT;
      r_prev_vec  <= 4'd0;
      r_hold_cnt  <= '0;
      r_good_cnt  <= '0;
      r_locked    <= 1'b0;
      r_phase_err <= 1'b0;
      r_cur_phase <= 2'd0;
      r_inst_cnt  <= '0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_prev_vec  <= w_vec;
      r_phase_err <= 1'b0;
      if (w_onehot) begin
        r_cur_phase <= w_enc;
      end

      if (w_hold) begin
        if (r_hold_cnt != HOLD_W'(MAX_HOLD)) begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end else begin
        r_hold_cnt <= '0;
      end

      case (r_state)
        S_HUNT: begin
          if (w_vec == 4'b0001) begin
            r_state    <= S_ACQUIRE;
            r_good_cnt <= '0;
            r_hold_cnt <= '0;
          end
        end
        S_ACQUIRE: begin
          if (w_err) begin
            r_state <= S_HUNT;
          end else if (w_wrap) begin
            if (r_good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
              r_state  <= S_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_good_cnt <= r_good_cnt + GOOD_W'(1);
            end
          end
        end
        S_LOCKED: begin
          if (w_err) begin
            r_state     <= S_HUNT;
            r_locked    <= 1'b0;
            r_phase_err <= 1'b1;
            if (r_err_cnt != 8'd255) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
          end else if (w_wrap) begin
            r_inst_cnt <= r_inst_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state  <= S_HUNT;
          r_locked <= 1'b0;
        end
      endcase

      // Placed last so a coincident increment is discarded.
      if (CLEAR) begin
        r_inst_cnt <= '0;
        r_err_cnt  <= 8'd0;
      end
    end
  end

  assign LOCKED    = r_locked;
  assign PHASE_ERR = r_phase_err;
  assign CUR_PHASE = r_cur_phase;
  assign INST_CNT  = r_inst_cnt;
  assign ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_phase_seq_monitor.sv
// Randomized and directed bench for phase_seq_monitor: a phase-index reference model
// fills a scoreboard queue that a separate monitor drains one edge at a time.
module tb_phase_seq_monitor;

  localparam int LOCK_COUNT = 2;
  localparam int MAX_HOLD   = 4;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ft = 1'b0, dc = 1'b0, ex = 1'b0, wb = 1'b0;
  logic             clear = 1'b0;
  logic             locked, phase_err;
  logic [1:0]       cur_phase;
  logic [CNT_W-1:0] inst_cnt;
  logic [7:0]       err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  phase_seq_monitor #(.LOCK_COUNT(LOCK_COUNT), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RESET(reset),
    .CLK_FT(ft), .CLK_DC(dc), .CLK_EX(ex), .CLK_WB(wb),
    .CLEAR(clear),
    .LOCKED(locked), .PHASE_ERR(phase_err), .CUR_PHASE(cur_phase),
    .INST_CNT(inst_cnt), .ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             locked;
    logic             perr;
    logic [1:0]       ph;
    logic [CNT_W-1:0] inst;
    logic [7:0]       err;
  } exp_t;

  exp_t q[$];

  // Reference model: phases as indices 0..3, run length of the current phase, mode 0/1/2.
  int m_prev_idx = -1;
  int m_run      = 0;
  int m_mode     = 0;
  int m_good     = 0;
  int m_inst     = 0;
  int m_err      = 0;
  int m_phase    = 0;
  bit m_locked   = 0;
  bit m_perr     = 0;

  function automatic int idx_of(input logic [3:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] v, input logic clr, input logic rst);
    int  idx;
    bit  same, adv, error, wrap;
    if (rst) begin
      m_prev_idx = -1; m_run = 0; m_mode = 0; m_good = 0;
      m_inst = 0; m_err = 0; m_phase = 0; m_locked = 0; m_perr = 0;
      return;
    end
    idx   = idx_of(v);
    same  = (idx >= 0) && (idx == m_prev_idx);
    adv   = (idx >= 0) && (m_prev_idx >= 0) && (idx == (m_prev_idx + 1) % 4);
    m_run = same ? m_run + 1 : 1;
    error = (idx < 0) || (same && m_run > MAX_HOLD) || ((idx >= 0) && !same && !adv);
    wrap  = adv && (idx == 0);
    m_perr = 0;
    if (idx >= 0) m_phase = idx;
    case (m_mode)
      0: if (idx == 0 && v == 4'b0001) begin m_mode = 1; m_good = 0; m_run = 1; end
      1: begin
        if (error) m_mode = 0;
        else if (wrap) begin
          m_good++;
          if (m_good == LOCK_COUNT) begin m_mode = 2; m_locked = 1; end
        end
      end
      default: begin
        if (error) begin
          m_mode = 0; m_locked = 0; m_perr = 1;
          if (m_err < 255) m_err++;
        end else if (wrap) m_inst = (m_inst + 1) % (1 << CNT_W);
      end
    endcase
    if (clr) begin m_inst = 0; m_err = 0; end
    m_prev_idx = idx;
  endtask

  int fail_prints = 0;
  task automatic report(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      if (fail_prints < 60) begin
        fail_prints++;
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
    end
  endtask

  // Monitor: every edge presents a fresh output set; compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        report("sb_locked",    int'(locked),    int'(e.locked));
        report("sb_phase_err", int'(phase_err), int'(e.perr));
        report("sb_cur_phase", int'(cur_phase), int'(e.ph));
        report("sb_inst_cnt",  int'(inst_cnt),  int'(e.inst));
        report("sb_err_cnt",   int'(err_cnt),   int'(e.err));
      end
    end
  end

  // Drives one sample at a negedge, queues the expectation, returns at the following negedge.
  task automatic drive(input logic [3:0] v, input logic clr = 1'b0, input logic rst = 1'b0);
    exp_t e;
    {wb, ex, dc, ft} = v;
    clear = clr;
    reset = rst;
    model_step(v, clr, rst);
    e.locked = m_locked; e.perr = m_perr; e.ph = 2'(m_phase);
    e.inst = CNT_W'(m_inst); e.err = 8'(m_err);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rotate(input int start, input int n);
    logic [3:0] v;
    for (int i = 0; i < n; i++) begin
      v = 4'b0001 << ((start + i) % 4);
      drive(v);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    report(name, act, req);
  endtask

  initial begin
    int          base, ph, r;
    logic [3:0]  v;
    @(negedge clk);

    // Reset state
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);
    chk("rst_locked", locked, 0); chk("rst_perr", phase_err, 0);
    chk("rst_phase", cur_phase, 0); chk("rst_inst", inst_cnt, 0); chk("rst_err", err_cnt, 0);
    $display("txn reset: outputs cleared");

    // Lock latency and instruction counting
    rotate(0, 8);
    chk("lock_edge7", locked, 0);
    drive(4'b0001);
    chk("lock_edge8", locked, 1);
    chk("lock_no_inst", inst_cnt, 0);
    rotate(1, 40);
    chk("inst_after_40", inst_cnt, 10);
    $display("txn lock: locked after edge 8, inst_cnt=%0d", inst_cnt);

    // Invalid 0000 while locked, then relock
    drive(4'b0000);
    chk("inv_perr", phase_err, 1); chk("inv_unlock", locked, 0); chk("inv_errcnt", err_cnt, 1);
    drive(4'b0001);
    chk("inv_pulse_one", phase_err, 0);
    rotate(1, 7);
    chk("relock_edge7", locked, 0);
    drive(4'b0001);
    chk("relock_edge8", locked, 1);
    $display("txn invalid: err_cnt=%0d relocked=%0d", err_cnt, locked);

    // Skip FT->EX, then a two-hot vector
    drive(4'b0100);
    chk("skip_perr", phase_err, 1); chk("skip_errcnt", err_cnt, 2);
    rotate(0, 9);
    drive(4'b0011);
    chk("twohot_perr", phase_err, 1); chk("twohot_errcnt", err_cnt, 3);
    $display("txn skip: err_cnt=%0d", err_cnt);

    // Hold limit on DC
    rotate(0, 9);
    base = inst_cnt;
    for (int i = 0; i < MAX_HOLD; i++) drive(4'b0010);
    chk("hold_max_ok", phase_err, 0);
    rotate(2, 3);
    chk("hold_inst", inst_cnt, base + 1);
    chk("hold_locked", locked, 1);
    for (int i = 0; i < MAX_HOLD; i++) drive(4'b0010);
    chk("hold_4_ok", phase_err, 0);
    drive(4'b0010);
    chk("overhold_perr", phase_err, 1); chk("overhold_unlock", locked, 0);
    $display("txn hold: overhold detected, err_cnt=%0d", err_cnt);

    // Randomized traffic
    ph = 0;
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      begin ph = (ph + 1) % 4; v = 4'b0001 << ph; end
      else if (r < 85) v = 4'b0001 << ph;
      else if (r < 90) v = 4'($urandom_range(0, 15));
      else begin ph = $urandom_range(0, 3); v = 4'b0001 << ph; end
      drive(v, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, ($urandom_range(0, 999) < 5) ? 1'b1 : 1'b0);
    end
    $display("txn random: 2000 samples issued");

    // Error counter saturation and CLEAR racing an increment
    drive(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      rotate(0, 9);
      drive(4'b0000);
    end
    chk("err_saturate", err_cnt, 255);
    rotate(0, 9);
    rotate(1, 3);
    drive(4'b0001, 1'b1);
    chk("clear_inst", inst_cnt, 0); chk("clear_err", err_cnt, 0); chk("clear_keeps_lock", locked, 1);
    $display("txn saturate/clear: err_cnt=%0d inst_cnt=%0d", err_cnt, inst_cnt);

    // Reset mid-rotation while locked
    rotate(1, 28);
    chk("pre_reset_inst", inst_cnt, 7);
    rotate(1, 2);
    drive(4'b1000, 1'b0, 1'b1);
    chk("mid_rst_locked", locked, 0); chk("mid_rst_inst", inst_cnt, 0);
    chk("mid_rst_phase", cur_phase, 0); chk("mid_rst_err", err_cnt, 0);
    rotate(0, 8);
    chk("post_rst_edge7", locked, 0);
    drive(4'b0001);
    chk("post_rst_edge8", locked, 1);
    $display("txn midreset: relocked=%0d", locked);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
